serial_adder_seq: RTL and testbench

//  Bit-serial adder. Accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake.

---
 rtl/serial_adder_seq.sv | 129 ++++++++++++
 tb/tb_serial_adder_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first, one bit per clock,
// with a registered carry; operands and result move over valid/ready handshakes.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // Full adder built from two half-adder stages plus an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_cout;
  assign ha1_s   = a_q[0] ^ b_q[0];
  assign ha1_c   = a_q[0] & b_q[0];
  assign ha2_s   = ha1_s ^ carry_q;
  assign ha2_c   = ha1_s & carry_q;
  assign fa_cout = ha1_c | ha2_c;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    sum_d       = sum_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          cnt_d      = '0;
          res_d      = '0;
          state_d    = StRun;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StRun: begin
        res_d   = {ha2_s, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == CntLast) begin
          // Counter parks at its last value instead of wrapping.
          state_d     = StDone;
          out_valid_d = 1'b1;
          sum_d       = {fa_cout, ha2_s, res_q[WIDTH-1:1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          sum_d       = '0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        sum_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sum_q       <= sum_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: directed corner cases plus a randomized
// back-to-back stream scored against plain integer addition.
module tb_serial_adder_seq;

  localparam int W = 8;
  localparam int NumRand = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;
  logic         busy;

  int checks = 0;
  int failures = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction and collects its result; comparisons are made by the caller.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W:0] sv, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) ok = 1'b0;
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      step();
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    sv = sum;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (sum !== '0) begin
      failures++;
      $display("FAIL reset_sum: got %h want 000", sum);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [W-1:0] tb_[3] = '{8'h01, 8'h01, 8'hFF};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   s;
    int           lat;
    bit           ok;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb_[i], tc[i], s, lat, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL directed_timeout[%0d]: got no handshake want completion", i);
      end
      checks++;
      if (lat != W) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      checks++;
      if (s !== model(ta[i], tb_[i], tc[i])) begin
        failures++;
        $display("FAIL directed_sum[%0d]: got %h want %h", i, s, model(ta[i], tb_[i], tc[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp_s;
    int         n;
    exp_s = model(8'h5A, 8'h3C, 1'b1);
    a = 8'h5A;
    b = 8'h3C;
    cin = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 4 * W) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      // Offer new operands while stalled; they must be ignored.
      in_valid = 1'b1;
      a = 8'hAA;
      checks++;
      if (out_valid !== 1'b1 || sum !== exp_s) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got valid=%b sum=%h want valid=1 sum=%h",
                 i, out_valid, sum, exp_s);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_ready[%0d]: got in_ready=%b busy=%b want 0 1", i, in_ready, busy);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== '0) begin
      failures++;
      $display("FAIL stall_release: got valid=%b in_ready=%b busy=%b sum=%h want 0 1 0 000",
               out_valid, in_ready, busy, sum);
    end
  endtask

  task automatic test_ignore_in_valid();
    int k;
    logic [W:0] exp_s;
    exp_s = model(8'h12, 8'h34, 1'b0);
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || sum !== '0) begin
      failures++;
      $display("FAIL run_outputs: got in_ready=%b busy=%b sum=%h want 0 1 000",
               in_ready, busy, sum);
    end
    step();
    step();
    k = 2;
    for (int i = 0; i < 2; i++) begin
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b1;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL run_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      step();
      k++;
    end
    in_valid = 1'b0;
    while (!out_valid && k < 4 * W) begin
      step();
      k++;
    end
    checks++;
    if (k != W) begin
      failures++;
      $display("FAIL ignore_latency: got %0d want %0d", k, W);
    end
    checks++;
    if (sum !== exp_s) begin
      failures++;
      $display("FAIL ignore_sum: got %h want %h", sum, exp_s);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [W:0] s;
    int         lat;
    bit         ok;
    // Abort three cycles into RUN.
    a = 8'h77;
    b = 8'h11;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      failures++;
      $display("FAIL abort_run: got in_ready=%b valid=%b busy=%b sum=%h want 1 0 0 000",
               in_ready, out_valid, busy, sum);
    end
    step();
    step();
    step();
    rst_n = 1'b1;
    run_op(8'h80, 8'h80, 1'b0, s, lat, ok);
    checks++;
    if (!ok || lat != W || s !== model(8'h80, 8'h80, 1'b0)) begin
      failures++;
      $display("FAIL abort_run_next: got ok=%b lat=%0d sum=%h want 1 %0d %h",
               ok, lat, s, W, model(8'h80, 8'h80, 1'b0));
    end
    // Abort while holding a result in DONE.
    a = 8'hC3;
    b = 8'h3D;
    cin = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      step();
      lat++;
    end
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      failures++;
      $display("FAIL abort_done: got in_ready=%b valid=%b busy=%b sum=%h want 1 0 0 000",
               in_ready, out_valid, busy, sum);
    end
    step();
    rst_n = 1'b1;
    run_op(8'h01, 8'hFE, 1'b1, s, lat, ok);
    checks++;
    if (!ok || s !== model(8'h01, 8'hFE, 1'b1)) begin
      failures++;
      $display("FAIL abort_done_next: got ok=%b sum=%h want 1 %h",
               ok, s, model(8'h01, 8'hFE, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int         sent = 0;
    int         got = 0;
    int         cyc = 0;
    int         bad = 0;
    bit         acc_pending = 1'b0;
    while (got < NumRand && cyc < 60000) begin
      if (acc_pending) begin
        in_valid = 1'b0;
        acc_pending = 1'b0;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          bad++;
          $display("FAIL rand_extra: got sum=%h want no result pending", sum);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e) begin
            failures++;
            bad++;
            if (bad < 10) $display("FAIL rand_sum[%0d]: got %h want %h", got, sum, e);
          end
        end
        got++;
      end
      if (!in_valid && sent < NumRand && $urandom_range(0, 3) != 0) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        in_valid = 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        sent++;
        acc_pending = 1'b1;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != NumRand || sent != NumRand || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_count: got results=%0d sent=%0d left=%0d want %0d %0d 0",
               got, sent, exp_q.size(), NumRand, NumRand);
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
